// File: rtl/pong_pkg.sv
// Shared constants and types for the pong ball/paddle collision logic.
// Playfield geometry, FSM state encoding and the ponto/sentido codes live
// here so the top level and the sector decoder agree on them.
package pong_pkg;

  // Right edge the ball must reach to meet the paddle, left wall bounce edge.
  localparam logic [9:0] PADDLE_X = 10'd636;
  localparam logic [9:0] WALL_X   = 10'd10;

  // Ball box is BALL_H pixels tall; its center sits BALL_HALF below the top.
  localparam int BALL_H    = 6;
  localparam int BALL_HALF = BALL_H / 2;

  // Number of one-hot return-angle sectors on the paddle face.
  localparam int N_SECTORS = 6;

  // Direction of travel.
  localparam logic [1:0] SENT_PADDLE = 2'b00;
  localparam logic [1:0] SENT_WALL   = 2'b01;

  // Point/event codes.
  localparam logic [1:0] PONTO_NONE = 2'b00;
  localparam logic [1:0] PONTO_MISS = 2'b01;
  localparam logic [1:0] PONTO_HIT  = 2'b10;

  typedef enum logic [2:0] {
    ST_SERVE,
    ST_TO_PADDLE,
    ST_TO_WALL,
    ST_MISS,
    ST_GAME_OVER
  } ball_state_t;

endpackage

// File: rtl/sector_decode.sv
// Maps the ball center and the paddle top edge to a one-hot return sector.
// Offset below the paddle top is split into BAND_W-pixel bands; a center above
// the paddle top counts as offset 0 and everything at or past five bands lands
// in the last sector.
module sector_decode
  import pong_pkg::*;
#(
  parameter int BAND_W = 10
) (
  input  logic [10:0]          center,
  input  logic [9:0]           pad_top,
  output logic [N_SECTORS-1:0] sector
);

  logic [10:0] top_ext;
  logic [10:0] off;
  logic [2:0]  band;

  assign top_ext = {1'b0, pad_top};

  // Clamp the offset at zero, find the highest band boundary it has passed.
  always_comb begin
    off    = (center >= top_ext) ? (center - top_ext) : '0;
    band   = '0;
    for (int k = 1; k < N_SECTORS; k++) begin
      if ({21'b0, off} >= 32'(k * BAND_W)) band = 3'(k);
    end
    sector = '0;
    sector[band] = 1'b1;
  end

endmodule

// File: rtl/ball_collision.sv
// Ball collision / scoring controller for a single-paddle pong game.
// Watches the ball box on each ball-step tick, decides paddle hit or miss,
// tracks direction, latches the return-angle sector on a hit and releases it
// when the ball bounces off the left wall.
// Optional feature: define BALL_COLLISION_SCORE_EN to build the score counters
// and the GAME_OVER end state; without it the scores and game_over read 0 and
// every miss simply re-serves.
module ball_collision
  import pong_pkg::*;
#(
  parameter int WIN_SCORE = 9,
  parameter int BAND_W    = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick,
  input  logic [9:0] x_I_Bola,
  input  logic [9:0] x_F_Bola,
  input  logic [9:0] y_S_Bola,
  input  logic [9:0] y_I_Bola,
  input  logic [9:0] Pos_barra_y_S,
  input  logic [9:0] Pos_barra_y_I,
  output logic [1:0] sentido,
  output logic       setor1,
  output logic       setor2,
  output logic       setor3,
  output logic       setor4,
  output logic       setor5,
  output logic       setor6,
  output logic [1:0] ponto,
  output logic [3:0] score_cpu,
  output logic [3:0] score_player,
  output logic       game_over
);

`ifdef BALL_COLLISION_SCORE_EN
  localparam bit SCORE_EN = 1'b1;
`else
  localparam bit SCORE_EN = 1'b0;
`endif

  // Scores are 4 bits wide, so the win threshold is taken modulo 16.
  localparam logic [3:0] WIN_Q = 4'(WIN_SCORE);

  ball_state_t          state;
  logic [N_SECTORS-1:0] setor_q;
  logic [N_SECTORS-1:0] setor_lat;
  logic [N_SECTORS-1:0] sec_now;
  logic [10:0]          ball_center;
  logic [3:0]           cpu_cnt;

  logic at_paddle;
  logic at_wall;
  logic hit_geom;
  logic hit_evt;
  logic miss_evt;
  logic win_hit;
  logic over_evt;

  assign ball_center = {1'b0, y_S_Bola} + 11'(BALL_HALF);

  sector_decode #(
    .BAND_W (BAND_W)
  ) u_sector_decode (
    .center  (ball_center),
    .pad_top (Pos_barra_y_S),
    .sector  (sec_now)
  );

  // Edge contact counts as a hit on both the top and bottom paddle edges.
  assign at_paddle = (x_F_Bola >= PADDLE_X);
  assign at_wall   = (x_I_Bola <= WALL_X);
  assign hit_geom  = (y_I_Bola >= Pos_barra_y_S) && (y_S_Bola <= Pos_barra_y_I);

  assign hit_evt  = tick && (state == ST_TO_PADDLE) && at_paddle &&  hit_geom;
  assign miss_evt = tick && (state == ST_TO_PADDLE) && at_paddle && !hit_geom;
  assign win_hit  = (cpu_cnt >= WIN_Q);
  assign over_evt = SCORE_EN && tick && (state == ST_MISS) && win_hit;

  // Main game FSM: direction, point pulse and sector outputs, all registered.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= ST_SERVE;
      sentido   <= SENT_PADDLE;
      ponto     <= PONTO_NONE;
      setor_q   <= '0;
      setor_lat <= '0;
    end else if (tick) begin
      case (state)
        ST_SERVE: begin
          sentido <= SENT_PADDLE;
          ponto   <= PONTO_NONE;
          setor_q <= '0;
          state   <= ST_TO_PADDLE;
        end
        ST_TO_PADDLE: begin
          if (hit_evt) begin
            sentido   <= SENT_WALL;
            ponto     <= PONTO_HIT;
            setor_lat <= sec_now;
            state     <= ST_TO_WALL;
          end else if (miss_evt) begin
            ponto   <= PONTO_MISS;
            setor_q <= '0;
            state   <= ST_MISS;
          end
        end
        ST_TO_WALL: begin
          // The hit pulse lasts exactly one tick interval.
          ponto <= PONTO_NONE;
          if (at_wall) begin
            sentido <= SENT_PADDLE;
            setor_q <= setor_lat;
            state   <= ST_TO_PADDLE;
          end
        end
        ST_MISS: begin
          ponto <= PONTO_NONE;
          state <= over_evt ? ST_GAME_OVER : ST_SERVE;
        end
        ST_GAME_OVER: begin
          sentido <= SENT_PADDLE;
          ponto   <= PONTO_NONE;
          setor_q <= '0;
        end
        default: begin
          state <= ST_SERVE;
        end
      endcase
    end
  end

`ifdef BALL_COLLISION_SCORE_EN
  logic [3:0] cpu_q;
  logic [3:0] player_q;
  logic       over_q;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  // Score counters saturate at 15; game_over latches until reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cpu_q    <= '0;
      player_q <= '0;
      over_q   <= 1'b0;
    end else begin
      if (hit_evt)  player_q <= sat_inc(player_q);
      if (miss_evt) cpu_q    <= sat_inc(cpu_q);
      if (over_evt) over_q   <= 1'b1;
    end
  end

  assign cpu_cnt      = cpu_q;
  assign score_cpu    = cpu_q;
  assign score_player = player_q;
  assign game_over    = over_q;
`else
  assign cpu_cnt      = '0;
  assign score_cpu    = '0;
  assign score_player = '0;
  assign game_over    = 1'b0;
`endif

  assign setor1 = setor_q[0];
  assign setor2 = setor_q[1];
  assign setor3 = setor_q[2];
  assign setor4 = setor_q[3];
  assign setor5 = setor_q[4];
  assign setor6 = setor_q[5];

endmodule

// File: tb/tb_ball_collision.sv
// Self-checking bench for ball_collision: reset values, a table of paddle
// contact geometries, hand-written multi-tick sequences and a randomized run
// against a behavioural game model.
module tb_ball_collision;

  localparam int WIN_SCORE = 9;
  localparam int BAND_W    = 10;
`ifdef BALL_COLLISION_SCORE_EN
  localparam bit SCORE_EN = 1'b1;
`else
  localparam bit SCORE_EN = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       tick  = 1'b0;
  logic [9:0] x_I_Bola = '0, x_F_Bola = '0, y_S_Bola = '0, y_I_Bola = '0;
  logic [9:0] Pos_barra_y_S = 10'd200, Pos_barra_y_I = 10'd260;
  logic [1:0] sentido, ponto;
  logic       setor1, setor2, setor3, setor4, setor5, setor6;
  logic [3:0] score_cpu, score_player;
  logic       game_over;
  logic [5:0] setors;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  ball_collision #(.WIN_SCORE(WIN_SCORE), .BAND_W(BAND_W)) dut (
    .clock(clock), .reset(reset), .tick(tick),
    .x_I_Bola(x_I_Bola), .x_F_Bola(x_F_Bola), .y_S_Bola(y_S_Bola), .y_I_Bola(y_I_Bola),
    .Pos_barra_y_S(Pos_barra_y_S), .Pos_barra_y_I(Pos_barra_y_I),
    .sentido(sentido),
    .setor1(setor1), .setor2(setor2), .setor3(setor3),
    .setor4(setor4), .setor5(setor5), .setor6(setor6),
    .ponto(ponto), .score_cpu(score_cpu), .score_player(score_player),
    .game_over(game_over)
  );

  assign setors = {setor6, setor5, setor4, setor3, setor2, setor1};

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic ball_mid();
    x_I_Bola = 10'd300; x_F_Bola = 10'd310; y_S_Bola = 10'd400; y_I_Bola = 10'd406;
  endtask

  task automatic ball_paddle(input int ys);
    x_I_Bola = 10'd626; x_F_Bola = 10'd636;
    y_S_Bola = 10'(ys); y_I_Bola = 10'(ys + 6);
  endtask

  task automatic ball_wall();
    x_I_Bola = 10'd10; x_F_Bola = 10'd20;
  endtask

  task automatic pulse();
    tick = 1'b1;
    @(posedge clock); #1;
    tick = 1'b0;
  endtask

  task automatic idle(input int n);
    tick = 1'b0;
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    tick  = 1'b0;
    reset = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
  endtask

  // ---------------- behavioural model ----------------
  typedef enum int { M_SERVE, M_PADDLE, M_WALL, M_MISS, M_OVER } mode_t;
  mode_t m_mode;
  int m_sentido, m_ponto, m_setor, m_latched, m_cpu, m_player, m_over;

  function automatic int ref_sector(input int ys, input int top);
    int c, off, n;
    c   = ys + 3;
    off = (c < top) ? 0 : c - top;
    n   = off / BAND_W;
    if (n > 5) n = 5;
    return 1 << n;
  endfunction

  task automatic model_reset();
    m_mode = M_SERVE; m_sentido = 0; m_ponto = 0; m_setor = 0; m_latched = 0;
    m_cpu = 0; m_player = 0; m_over = 0;
  endtask

  task automatic model_tick();
    if (!tick) return;
    case (m_mode)
      M_SERVE: begin m_sentido = 0; m_ponto = 0; m_setor = 0; m_mode = M_PADDLE; end
      M_PADDLE: if (int'(x_F_Bola) >= 636) begin
        if (y_I_Bola >= Pos_barra_y_S && y_S_Bola <= Pos_barra_y_I) begin
          m_sentido = 1; m_ponto = 2;
          m_latched = ref_sector(int'(y_S_Bola), int'(Pos_barra_y_S));
          if (m_player < 15) m_player++;
          m_mode = M_WALL;
        end else begin
          m_ponto = 1; m_setor = 0;
          if (m_cpu < 15) m_cpu++;
          m_mode = M_MISS;
        end
      end
      M_WALL: begin
        m_ponto = 0;
        if (int'(x_I_Bola) <= 10) begin m_sentido = 0; m_setor = m_latched; m_mode = M_PADDLE; end
      end
      M_MISS: begin
        m_ponto = 0;
        if (SCORE_EN && m_cpu >= WIN_SCORE) begin m_over = 1; m_mode = M_OVER; end
        else m_mode = M_SERVE;
      end
      default: ;
    endcase
  endtask

  function automatic int pack_dut();
    return {13'b0, sentido, ponto, setors, score_cpu, score_player, game_over};
  endfunction

  function automatic int pack_model();
    int c, p, o;
    c = SCORE_EN ? m_cpu : 0;
    p = SCORE_EN ? m_player : 0;
    o = SCORE_EN ? m_over : 0;
    return (m_sentido << 17) | (m_ponto << 15) | (m_setor << 9) | (c << 5) | (p << 1) | o;
  endfunction

  // ---------------- table of paddle contacts ----------------
  typedef struct {
    int ys;
    bit hit;
    int setor;
  } vec_t;
  vec_t vecs[11];

  initial begin
    vecs[0]  = '{217, 1'b1, 6'b000100};  // center 220, offset 20 -> sector 3
    vecs[1]  = '{227, 1'b1, 6'b001000};  // center 230, offset 30 -> sector 4
    vecs[2]  = '{194, 1'b1, 6'b000001};  // bottom on paddle top edge
    vecs[3]  = '{260, 1'b1, 6'b100000};  // top on paddle bottom edge
    vecs[4]  = '{193, 1'b0, 0};          // one pixel above
    vecs[5]  = '{100, 1'b0, 0};
    vecs[6]  = '{261, 1'b0, 0};          // one pixel below
    vecs[7]  = '{206, 1'b1, 6'b000001};  // offset 9
    vecs[8]  = '{207, 1'b1, 6'b000010};  // offset 10
    vecs[9]  = '{246, 1'b1, 6'b010000};  // offset 49
    vecs[10] = '{247, 1'b1, 6'b100000};  // offset 50

    // Reset state while reset is held low.
    ball_mid();
    #12;
    chk("rst_sentido", sentido, 0);
    chk("rst_ponto", ponto, 0);
    chk("rst_setors", setors, 0);
    chk("rst_score_cpu", score_cpu, 0);
    chk("rst_score_player", score_player, 0);
    chk("rst_game_over", game_over, 0);
    @(posedge clock); #1;
    reset = 1'b1;

    // Table: serve, then the ball arrives at the paddle; on hits, bounce off the wall.
    for (int i = 0; i < 11; i++) begin
      do_reset();
      ball_mid(); pulse();
      ball_paddle(vecs[i].ys); pulse();
      chk("tbl_ponto", ponto, vecs[i].hit ? 2 : 1);
      chk("tbl_sentido", sentido, vecs[i].hit ? 1 : 0);
      chk("tbl_player", score_player, (SCORE_EN && vecs[i].hit) ? 1 : 0);
      chk("tbl_cpu", score_cpu, (SCORE_EN && !vecs[i].hit) ? 1 : 0);
      chk("tbl_setors_pre", setors, 0);
      if (vecs[i].hit) begin
        ball_mid(); pulse();
        chk("tbl_ponto_end", ponto, 0);
        chk("tbl_sentido_hold", sentido, 1);
        ball_wall(); pulse();
        chk("tbl_setor", setors, vecs[i].setor);
        chk("tbl_sentido_wall", sentido, 0);
      end
    end

    // Miss pulse holds across idle cycles until the next tick, then re-serves.
    do_reset();
    ball_mid(); pulse();
    ball_paddle(100); pulse();
    chk("miss_ponto", ponto, 1);
    idle(3);
    chk("miss_ponto_held", ponto, 1);
    ball_mid(); pulse();
    chk("miss_ponto_clr", ponto, 0);
    ball_paddle(217); pulse();
    chk("serve_no_hit", ponto, 0);
    pulse();
    chk("after_serve_hit", ponto, 2);
    // Hit pulse holds across idle cycles too.
    ball_mid(); idle(4);
    chk("hit_ponto_held", ponto, 2);
    // Ticks with no wall contact leave sector and direction untouched.
    pulse(); pulse();
    chk("nowall_sentido", sentido, 1);
    chk("nowall_setors", setors, 0);
    ball_wall(); pulse();
    chk("wall_setor3", setors, 6'b000100);
    // No tick: ball at paddle does nothing.
    ball_paddle(100); idle(3);
    chk("notick_ponto", ponto, 0);
    chk("notick_setor", setors, 6'b000100);

    // Nine consecutive misses.
    do_reset();
    for (int i = 1; i <= 9; i++) begin
      ball_mid(); pulse();
      ball_paddle(100); pulse();
      chk("nine_ponto", ponto, 1);
      chk("nine_cpu", score_cpu, SCORE_EN ? i : 0);
      chk("nine_over_early", game_over, 0);
      ball_mid(); pulse();
    end
    chk("nine_game_over", game_over, SCORE_EN ? 1 : 0);
    ball_paddle(100); pulse(); pulse();
    chk("over_ignores_ticks", ponto, SCORE_EN ? 0 : 1);
    chk("over_cpu_hold", score_cpu, SCORE_EN ? 9 : 0);
    chk("over_game_over_hold", game_over, SCORE_EN ? 1 : 0);

    // Reset asserted in TO_WALL at the same moment as a tick.
    do_reset();
    ball_mid(); pulse();
    ball_paddle(217); pulse();
    chk("pre_rst_ponto", ponto, 2);
    ball_mid();
    tick = 1'b1; reset = 1'b0;
    #1;
    chk("arst_ponto", ponto, 0);
    chk("arst_sentido", sentido, 0);
    chk("arst_player", score_player, 0);
    chk("arst_setors", setors, 0);
    @(posedge clock); #1;
    chk("arst_edge_ponto", ponto, 0);
    chk("arst_edge_sentido", sentido, 0);
    tick = 1'b0; reset = 1'b1;
    ball_paddle(217); pulse();
    chk("post_rst_serve", ponto, 0);
    pulse();
    chk("post_rst_hit", ponto, 2);
    chk("post_rst_sentido", sentido, 1);

    // Randomized run against the model.
    do_reset();
    model_reset();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      int pt, ys;
      if (cyc % 500 == 499) begin
        do_reset();
        model_reset();
      end
      tick = ($urandom_range(0, 99) < 50);
      x_F_Bola = ($urandom_range(0, 99) < 30) ? 10'(636 + $urandom_range(0, 3))
                                                : 10'($urandom_range(20, 635));
      x_I_Bola = ($urandom_range(0, 99) < 30) ? 10'($urandom_range(0, 10))
                                                : 10'($urandom_range(11, 600));
      pt = $urandom_range(0, 900);
      Pos_barra_y_S = 10'(pt);
      Pos_barra_y_I = 10'(pt + 60);
      ys = pt + $urandom_range(0, 90) - 20;
      if (ys < 0) ys = 0;
      y_S_Bola = 10'(ys);
      y_I_Bola = 10'(ys + 6);
      model_tick();
      @(posedge clock); #1;
      chk("rand_outputs", pack_dut(), pack_model());
    end
    tick = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
